// File: rtl/scedma_chnlsched.sv
// scedma_chnlsched: round-robin job scheduler in front of a single scedma_chnl.
//
// Each requester owns a one-deep descriptor slot. Full slots are granted
// round-robin. The granted descriptor is latched onto o_chnl_cfg, the channel
// is started with a one-cycle pulse, and the scheduler waits for done.
// Zero-length jobs and watchdog expiry complete with an error flag.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_req_valid/i_req_cfg descriptor offer per requester
//   o_req_ready           slot empty (registered)
//   o_chnl_cfg            registered descriptor to the channel
//   o_chnl_start          one-cycle start pulse
//   i_chnl_busy           channel busy
//   i_chnl_done           channel done pulse
//   o_cmpl, o_cmpl_err    per-requester completion pulse and error qualifier
//   o_cur_id              currently granted requester
//   o_busy                scheduler not idle
//   o_intr                [0] any completion, [1] completion with error

package scedma_pkg;
  typedef struct packed {
    logic [31:0] srcaddr;
    logic [31:0] dstaddr;
    logic [15:0] transsize;
  } chnlcfg_t;
endpackage

module scedma_chnlsched
  import scedma_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TOW  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NREQ-1:0]           i_req_valid,
  input  chnlcfg_t [NREQ-1:0]       i_req_cfg,
  output logic [NREQ-1:0]           o_req_ready,
  output chnlcfg_t                  o_chnl_cfg,
  output logic                      o_chnl_start,
  input  logic                      i_chnl_busy,
  input  logic                      i_chnl_done,
  output logic [NREQ-1:0]           o_cmpl,
  output logic                      o_cmpl_err,
  output logic [2:0]                o_cur_id,
  output logic                      o_busy,
  output logic [7:0]                o_intr
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW:0] NreqW = NREQ[IDW:0];
  // Watchdog fires on the RUN cycle where it would step to all-ones.
  localparam logic [TOW-1:0] WdLast = {{(TOW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {StIdle, StStart, StRun, StCmpl} state_e;

  state_e           r_state;
  chnlcfg_t         r_slot [NREQ];
  logic [NREQ-1:0]  r_full;
  logic [IDW-1:0]   r_rr;
  logic [IDW-1:0]   r_cur_id;
  logic [TOW-1:0]   r_wd;
  chnlcfg_t         r_chnl_cfg;
  logic             r_chnl_start;
  logic [NREQ-1:0]  r_cmpl;
  logic             r_cmpl_err;
  logic [7:0]       r_intr;

  logic [NREQ-1:0]  w_acc;
  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic [IDW:0]     w_sum;
  logic [IDW:0]     w_rr_sum;
  logic [IDW-1:0]   w_rr_next;

  assign w_acc = i_req_valid & ~r_full;

  // First full slot searching rr, rr+1, ... mod NREQ.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr} + (IDW+1)'(k);
      if (w_sum >= NreqW) w_sum = w_sum - NreqW;
      if (!w_found && r_full[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_sum[IDW-1:0];
      end
    end
    w_rr_sum  = {1'b0, w_gnt} + (IDW+1)'(1);
    w_rr_next = (w_rr_sum >= NreqW) ? '0 : w_rr_sum[IDW-1:0];
  end

  // Slots: a slot can only be cleared while full, and only accepted while
  // empty, so accept and clear never collide on the same bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_full <= '0;
      for (int i = 0; i < NREQ; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_acc[i]) begin
          r_full[i] <= 1'b1;
          r_slot[i] <= i_req_cfg[i];
        end else if (r_cmpl[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Outputs are registered on the transition into the state they belong to.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_rr         <= '0;
      r_cur_id     <= '0;
      r_wd         <= '0;
      r_chnl_cfg   <= '0;
      r_chnl_start <= 1'b0;
      r_cmpl       <= '0;
      r_cmpl_err   <= 1'b0;
      r_intr       <= '0;
    end else begin
      r_chnl_start <= 1'b0;
      r_cmpl       <= '0;
      r_cmpl_err   <= 1'b0;
      r_intr       <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_found && !i_chnl_busy) begin
            r_chnl_cfg <= r_slot[w_gnt];
            r_cur_id   <= w_gnt;
            r_rr       <= w_rr_next;
            if (r_slot[w_gnt].transsize == '0) begin
              // Zero-length: never start the channel, complete with error.
              r_state    <= StCmpl;
              r_cmpl     <= NREQ'(1) << w_gnt;
              r_cmpl_err <= 1'b1;
              r_intr     <= 8'h03;
            end else begin
              r_state      <= StStart;
              r_chnl_start <= 1'b1;
            end
          end
        end
        StStart: begin
          r_wd    <= '0;
          r_state <= StRun;
        end
        StRun: begin
          r_wd <= r_wd + 1'b1;
          if (i_chnl_done) begin
            r_state <= StCmpl;
            r_cmpl  <= NREQ'(1) << r_cur_id;
            r_intr  <= 8'h01;
          end else if (r_wd == WdLast) begin
            // Channel is left running; IDLE waits for its busy to drop.
            r_state    <= StCmpl;
            r_cmpl     <= NREQ'(1) << r_cur_id;
            r_cmpl_err <= 1'b1;
            r_intr     <= 8'h03;
          end
        end
        StCmpl: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready  = ~r_full;
  assign o_chnl_cfg   = r_chnl_cfg;
  assign o_chnl_start = r_chnl_start;
  assign o_cmpl       = r_cmpl;
  assign o_cmpl_err   = r_cmpl_err;
  assign o_cur_id     = 3'(r_cur_id);
  assign o_busy       = (r_state != StIdle);
  assign o_intr       = r_intr;

endmodule

// File: tb/tb_scedma_chnlsched.sv
module tb_scedma_chnlsched;
  import scedma_pkg::*;

  localparam int unsigned NREQ = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  chnlcfg_t [NREQ-1:0]  req_cfg;
  logic [NREQ-1:0]      req_ready;
  chnlcfg_t             chnl_cfg;
  logic                 chnl_start;
  logic                 chnl_busy;
  logic                 chnl_done;
  logic [NREQ-1:0]      cmpl;
  logic                 cmpl_err;
  logic [2:0]           cur_id;
  logic                 busy;
  logic [7:0]           intr;

  int n_chk  = 0;
  int n_fail = 0;

  scedma_chnlsched #(.NREQ(NREQ), .TOW(4)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .i_req_cfg    (req_cfg),
    .o_req_ready  (req_ready),
    .o_chnl_cfg   (chnl_cfg),
    .o_chnl_start (chnl_start),
    .i_chnl_busy  (chnl_busy),
    .i_chnl_done  (chnl_done),
    .o_cmpl       (cmpl),
    .o_cmpl_err   (cmpl_err),
    .o_cur_id     (cur_id),
    .o_busy       (busy),
    .o_intr       (intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic chnlcfg_t mk_cfg(input int id, input logic [15:0] tsz);
    chnlcfg_t c;
    c.srcaddr   = 32'h1000_0000 + 32'(id);
    c.dstaddr   = 32'h2000_0000 + 32'(id);
    c.transsize = tsz;
    return c;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Checks the current cycle first, then advances up to a bounded budget.
  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (chnl_start) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check(tag, 96'(seen), 96'(1));
  endtask

  // Serve one job: start, one RUN cycle, done, completion.
  task automatic serve(input int id);
    wait_start($sformatf("start_%0d", id));
    check($sformatf("cur_id_%0d", id), 96'(cur_id), 96'(id));
    check($sformatf("cfg_%0d", id), 96'(chnl_cfg), 96'(mk_cfg(id, 16'(id + 1))));
    step();
    chnl_done = 1'b1;
    step();
    chnl_done = 1'b0;
    check($sformatf("cmpl_%0d", id), 96'(cmpl), 96'(4'b0001 << id));
    check($sformatf("cmpl_err_%0d", id), 96'(cmpl_err), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    chnlcfg_t c1;
    reset     = 1'b1;
    req_valid = '0;
    req_cfg   = '0;
    chnl_busy = 1'b0;
    chnl_done = 1'b0;
    #1;
    // Reset values.
    check("rst_ready", 96'(req_ready), 96'(4'hf));
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_start", 96'(chnl_start), 96'(0));
    check("rst_cmpl", 96'(cmpl), 96'(0));
    check("rst_cur_id", 96'(cur_id), 96'(0));
    check("rst_intr", 96'(intr), 96'(0));
    check("rst_cfg", 96'(chnl_cfg), 96'(0));
    step();
    reset = 1'b0;
    step();

    // Single job from requester 1, done 6 cycles after start.
    c1 = mk_cfg(1, 16'd4);
    req_cfg[1]   = c1;
    req_valid[1] = 1'b1;
    step();                                   // T+1
    req_valid[1] = 1'b0;
    check("t1_ready_full", 96'(req_ready), 96'(4'b1101));
    check("t1_no_start_t1", 96'(chnl_start), 96'(0));
    step();                                   // T+2 = S
    check("t1_start", 96'(chnl_start), 96'(1));
    check("t1_cur_id", 96'(cur_id), 96'(1));
    check("t1_busy", 96'(busy), 96'(1));
    for (int i = 1; i <= 5; i++) begin
      step();                                 // S+1..S+5
      check($sformatf("t1_cfg_run%0d", i), 96'(chnl_cfg), 96'(c1));
      check($sformatf("t1_start_low%0d", i), 96'(chnl_start), 96'(0));
    end
    step();                                   // S+6
    chnl_done = 1'b1;
    step();                                   // S+7
    chnl_done = 1'b0;
    check("t1_cmpl", 96'(cmpl), 96'(4'b0010));
    check("t1_cmpl_err", 96'(cmpl_err), 96'(0));
    check("t1_intr", 96'(intr), 96'(8'h01));
    check("t1_ready_in_cmpl", 96'(req_ready[1]), 96'(0));
    step();
    check("t1_ready_after", 96'(req_ready), 96'(4'hf));
    check("t1_cmpl_gone", 96'(cmpl), 96'(0));
    check("t1_idle", 96'(busy), 96'(0));

    // All four at once from rr=0; requester 0 re-offers during its cmpl.
    do_reset();
    for (int i = 0; i < NREQ; i++) req_cfg[i] = mk_cfg(i, 16'(i + 1));
    req_valid = 4'hf;
    step();
    req_valid = '0;
    check("t2_all_full", 96'(req_ready), 96'(0));
    serve(0);
    req_valid[0] = 1'b1;                      // re-offer in cmpl cycle
    step();
    check("t2_ready_reopen", 96'(req_ready[0]), 96'(1));
    step();
    req_valid[0] = 1'b0;
    check("t2_reaccepted", 96'(req_ready[0]), 96'(0));
    serve(1);
    serve(2);
    serve(3);
    serve(0);
    step();
    step();
    check("t2_drained", 96'(req_ready), 96'(4'hf));

    // Zero-length job from requester 2.
    req_cfg[2]   = mk_cfg(2, 16'd0);
    req_valid[2] = 1'b1;
    step();                                   // grant cycle
    req_valid[2] = 1'b0;
    check("t3_no_start_g", 96'(chnl_start), 96'(0));
    step();
    check("t3_no_start", 96'(chnl_start), 96'(0));
    check("t3_cmpl", 96'(cmpl), 96'(4'b0100));
    check("t3_cmpl_err", 96'(cmpl_err), 96'(1));
    check("t3_intr", 96'(intr), 96'(8'h03));
    step();
    check("t3_intr_gone", 96'(intr), 96'(0));
    check("t3_idle", 96'(busy), 96'(0));
    check("t3_ready", 96'(req_ready), 96'(4'hf));

    // Watchdog (TOW=4): rr=3, so slot 3 goes first and times out.
    req_cfg[0] = mk_cfg(0, 16'd1);
    req_cfg[3] = mk_cfg(3, 16'd4);
    req_valid  = 4'b1001;
    step();
    req_valid = '0;
    wait_start("t4_start");
    check("t4_cur_id", 96'(cur_id), 96'(3));
    chnl_busy = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();                                 // RUN cycles 1..15
      check($sformatf("t4_no_cmpl%0d", i), 96'(cmpl), 96'(0));
    end
    step();
    check("t4_cmpl", 96'(cmpl), 96'(4'b1000));
    check("t4_cmpl_err", 96'(cmpl_err), 96'(1));
    check("t4_intr", 96'(intr), 96'(8'h03));
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t4_held%0d", i), 96'(chnl_start), 96'(0));
    end
    check("t4_slot0_pending", 96'(req_ready), 96'(4'b1110));
    chnl_busy = 1'b0;
    check("t4_no_start_yet", 96'(chnl_start), 96'(0));
    step();
    check("t4_start_after_busy", 96'(chnl_start), 96'(1));
    check("t4_cur_id0", 96'(cur_id), 96'(0));
    step();
    chnl_done = 1'b1;
    step();
    chnl_done = 1'b0;
    check("t4_cmpl0", 96'(cmpl), 96'(4'b0001));
    step();

    // chnl_busy high in IDLE with slot 0 full.
    chnl_busy    = 1'b1;
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t5_no_grant%0d", i), 96'({busy, chnl_start}), 96'(0));
    end
    chnl_busy = 1'b0;
    step();
    check("t5_start", 96'(chnl_start), 96'(1));
    step();
    chnl_done = 1'b1;
    step();
    chnl_done = 1'b0;
    check("t5_cmpl", 96'(cmpl), 96'(4'b0001));
    step();

    // Reset mid-RUN with slots 1 and 3 full.
    req_valid = 4'b1010;
    step();
    req_valid = '0;
    wait_start("t6_start");
    step();
    step();
    check("t6_running", 96'(busy), 96'(1));
    reset = 1'b1;
    #1;
    check("t6_rst_ready", 96'(req_ready), 96'(4'hf));
    check("t6_rst_busy", 96'(busy), 96'(0));
    check("t6_rst_start", 96'(chnl_start), 96'(0));
    step();
    reset = 1'b0;
    chnl_done = 1'b1;
    step();
    chnl_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t6_quiet%0d", i), 96'({cmpl, chnl_start, busy}), 96'(0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
